// File: rtl/img_proc_pkg.sv
// img_proc_pkg
//   Shared types and constants for the binary image-processing chain
//   (binarize -> erode -> dilate -> bbox_detect).
//   - COORD_W / coord_t : pixel coordinate width and type.
//   - bbox_state_e      : bounding-box detector frame state.
//   - BOX_COLOR         : RGB colour used to draw the box border on the overlay.
//   - sat_inc()         : coordinate increment that saturates at a limit.
package img_proc_pkg;

  localparam int COORD_W = 16;
  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } bbox_state_e;

  localparam logic [23:0] BOX_COLOR = 24'hFF0000;

  // Increment v, holding at lim once reached.
  function automatic coord_t sat_inc(input coord_t v, input coord_t lim);
    return (v >= lim) ? lim : coord_t'(v + coord_t'(1));
  endfunction

endpackage

// File: rtl/bbox_minmax.sv
// bbox_minmax
//   Running minimum/maximum of one coordinate axis over a frame.
//   Ports:
//     video_clk, rst_n : clock, async active-low reset
//     clr              : reload sentinels (min=all ones, max=0)
//     en               : fold coord into the running min/max this cycle
//     coord            : coordinate of the current pixel
//     min_nxt, max_nxt : next-state min/max, i.e. including this cycle's
//                        pixel; lets the parent latch a frame result on the
//                        same cycle as the last pixel.
module bbox_minmax
  import img_proc_pkg::*;
(
  input  logic   video_clk,
  input  logic   rst_n,
  input  logic   clr,
  input  logic   en,
  input  coord_t coord,
  output coord_t min_nxt,
  output coord_t max_nxt
);

  coord_t min_q;
  coord_t max_q;

  always_comb begin
    min_nxt = min_q;
    max_nxt = max_q;
    if (clr) begin
      min_nxt = '1;
      max_nxt = '0;
    end else if (en) begin
      if (coord < min_q) min_nxt = coord;
      if (coord > max_q) max_nxt = coord;
    end
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_nxt;
      max_q <= max_nxt;
    end
  end

endmodule

// File: rtl/bbox_detect.sv
// bbox_detect
//   Tracks the x/y extent and count of foreground pixels in the cleaned
//   1-bit stream from the dilate stage and latches a bounding box at the end
//   of each complete frame. The stream itself passes through untouched.
//
//   Ports:
//     video_clk, rst_n       : pixel clock, async active-low reset
//     bin_vs, bin_de         : frame sync (high during frame), active-pixel enable
//     bin_data               : pixel, 1 = foreground
//     box_x_min/x_max        : left/right column of latched box
//     box_y_min/y_max        : top/bottom line of latched box
//     pix_cnt                : foreground pixel count of latched frame (saturating)
//     box_valid              : latched frame had pix_cnt >= MIN_PIXELS
//     result_vld             : result strobe (see below)
//   Optional overlay (compile with BBOX_OVERLAY_EN defined):
//     ovl_vs, ovl_de         : bin_vs / bin_de delayed one cycle
//     ovl_data               : BOX_COLOR on the border of the last valid box,
//                              else {24{bin_data}}; aligned with ovl_de
//
//   Handshake: result_vld is a one-cycle strobe with no back-pressure. It is
//   high for exactly the cycle after bin_vs falls at the end of a complete
//   frame; the box_*/pix_cnt/box_valid values are valid while it is high and
//   hold until the next strobe.
module bbox_detect
  import img_proc_pkg::*;
#(
  parameter int IMG_WIDTH  = 1280,
  parameter int IMG_HEIGHT = 720,
  parameter int MIN_PIXELS = 16,
  parameter int CNT_W      = 24
) (
  input  logic             video_clk,
  input  logic             rst_n,
  input  logic             bin_vs,
  input  logic             bin_de,
  input  logic             bin_data,
  output logic [15:0]      box_x_min,
  output logic [15:0]      box_x_max,
  output logic [15:0]      box_y_min,
  output logic [15:0]      box_y_max,
  output logic [CNT_W-1:0] pix_cnt,
  output logic             box_valid,
  output logic             result_vld
`ifdef BBOX_OVERLAY_EN
  ,
  output logic             ovl_vs,
  output logic             ovl_de,
  output logic [23:0]      ovl_data
`endif
);

  localparam coord_t X_LAST = coord_t'(IMG_WIDTH - 1);
  localparam coord_t Y_LAST = coord_t'(IMG_HEIGHT - 1);

  bbox_state_e      state;
  bbox_state_e      state_nxt;
  logic             vs_d;
  logic             de_d;
  logic             armed;
  logic             rise;
  logic             fall;
  logic             clr;
  logic             acc_en;
  logic             latch;
  coord_t           x_q;
  coord_t           y_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  coord_t           x_min_nxt;
  coord_t           x_max_nxt;
  coord_t           y_min_nxt;
  coord_t           y_max_nxt;

  // armed stays low after reset until bin_vs has been seen low, so a frame
  // already in progress when reset releases is not mistaken for a new frame.
  assign rise = bin_vs & ~vs_d & armed;
  assign fall = ~bin_vs & vs_d;

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d  <= 1'b0;
      de_d  <= 1'b0;
      armed <= 1'b0;
      state <= S_IDLE;
    end else begin
      vs_d  <= bin_vs;
      de_d  <= bin_de;
      if (!bin_vs) armed <= 1'b1;
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    acc_en    = 1'b0;
    latch     = 1'b0;
    case (state)
      S_IDLE: begin
        if (rise) begin
          clr       = 1'b1;
          state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        // The pixel on the fall cycle still belongs to the frame.
        acc_en = bin_de & bin_data;
        if (fall) begin
          latch     = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // x is the column of the pixel presented this cycle; y is the line.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (clr) begin
      x_q <= '0;
      y_q <= '0;
    end else if (state == S_ACTIVE) begin
      x_q <= bin_de ? sat_inc(x_q, X_LAST) : '0;
      if (de_d && !bin_de) y_q <= sat_inc(y_q, Y_LAST);
    end
  end

  always_comb begin
    cnt_nxt = cnt_q;
    if (clr) cnt_nxt = '0;
    else if (acc_en && (cnt_q != '1)) cnt_nxt = cnt_q + 1'b1;
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_nxt;
  end

  bbox_minmax u_x_acc (
    .video_clk (video_clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .en        (acc_en),
    .coord     (x_q),
    .min_nxt   (x_min_nxt),
    .max_nxt   (x_max_nxt)
  );

  bbox_minmax u_y_acc (
    .video_clk (video_clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .en        (acc_en),
    .coord     (y_q),
    .min_nxt   (y_min_nxt),
    .max_nxt   (y_max_nxt)
  );

  // Latch uses next-state accumulators so a pixel on the fall cycle counts.
  // An empty frame reports a zero box even when it qualifies as valid,
  // rather than exposing the min/max sentinels.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      box_x_min  <= '0;
      box_x_max  <= '0;
      box_y_min  <= '0;
      box_y_max  <= '0;
      pix_cnt    <= '0;
      box_valid  <= 1'b0;
      result_vld <= 1'b0;
    end else begin
      result_vld <= latch;
      if (latch) begin
        pix_cnt <= cnt_nxt;
        if (cnt_nxt >= CNT_W'(MIN_PIXELS)) begin
          box_valid <= 1'b1;
          if (cnt_nxt != '0) begin
            box_x_min <= x_min_nxt;
            box_x_max <= x_max_nxt;
            box_y_min <= y_min_nxt;
            box_y_max <= y_max_nxt;
          end else begin
            box_x_min <= '0;
            box_x_max <= '0;
            box_y_min <= '0;
            box_y_max <= '0;
          end
        end else begin
          box_valid <= 1'b0;
          box_x_min <= '0;
          box_x_max <= '0;
          box_y_min <= '0;
          box_y_max <= '0;
        end
      end
    end
  end

`ifdef BBOX_OVERLAY_EN
  logic on_border;
  logic in_x;
  logic in_y;

  // Border test against the box latched from the previous frame.
  always_comb begin
    in_x      = (x_q >= box_x_min) && (x_q <= box_x_max);
    in_y      = (y_q >= box_y_min) && (y_q <= box_y_max);
    on_border = 1'b0;
    if (box_valid && (state == S_ACTIVE) && bin_de) begin
      on_border = (((x_q == box_x_min) || (x_q == box_x_max)) && in_y) ||
                  (((y_q == box_y_min) || (y_q == box_y_max)) && in_x);
    end
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      ovl_vs   <= 1'b0;
      ovl_de   <= 1'b0;
      ovl_data <= '0;
    end else begin
      ovl_vs   <= bin_vs;
      ovl_de   <= bin_de;
      ovl_data <= on_border ? BOX_COLOR : {24{bin_data}};
    end
  end
`endif

endmodule

// File: tb/tb_bbox_detect.sv
// tb_bbox_detect
//   Directed frames into two bbox_detect instances (MIN_PIXELS=4 and 3) on a
//   16x8 image. Expected results are pushed when a frame is issued; monitors
//   pop and compare on every result_vld strobe.
module tb_bbox_detect;

  localparam int W = 16;
  localparam int H = 8;

  logic        video_clk = 1'b0;
  logic        rst_n;
  logic        bin_vs;
  logic        bin_de;
  logic        bin_data;

  logic [15:0] box_x_min, box_x_max, box_y_min, box_y_max;
  logic [23:0] pix_cnt;
  logic        box_valid, result_vld;
  logic [15:0] b3_x_min, b3_x_max, b3_y_min, b3_y_max;
  logic [23:0] b3_cnt;
  logic        b3_valid, b3_vld;
`ifdef BBOX_OVERLAY_EN
  logic        ovl_vs, ovl_de, o3_vs, o3_de;
  logic [23:0] ovl_data, o3_data;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [88:0] exp_q[$];
  logic [88:0] exp3_q[$];

  logic [31:0] img [0:H-1];
  int          len [0:H-1];

  // ---------------- clock / DUTs ----------------
  always #5 video_clk = ~video_clk;

  bbox_detect #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MIN_PIXELS(4), .CNT_W(24)) dut (
    .video_clk (video_clk), .rst_n (rst_n),
    .bin_vs (bin_vs), .bin_de (bin_de), .bin_data (bin_data),
    .box_x_min (box_x_min), .box_x_max (box_x_max),
    .box_y_min (box_y_min), .box_y_max (box_y_max),
    .pix_cnt (pix_cnt), .box_valid (box_valid), .result_vld (result_vld)
`ifdef BBOX_OVERLAY_EN
    , .ovl_vs (ovl_vs), .ovl_de (ovl_de), .ovl_data (ovl_data)
`endif
  );

  bbox_detect #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MIN_PIXELS(3), .CNT_W(24)) dut3 (
    .video_clk (video_clk), .rst_n (rst_n),
    .bin_vs (bin_vs), .bin_de (bin_de), .bin_data (bin_data),
    .box_x_min (b3_x_min), .box_x_max (b3_x_max),
    .box_y_min (b3_y_min), .box_y_max (b3_y_max),
    .pix_cnt (b3_cnt), .box_valid (b3_valid), .result_vld (b3_vld)
`ifdef BBOX_OVERLAY_EN
    , .ovl_vs (o3_vs), .ovl_de (o3_de), .ovl_data (o3_data)
`endif
  );

  // ---------------- helpers ----------------
  function automatic logic [88:0] pack(input logic [15:0] xmin, input logic [15:0] xmax,
                                       input logic [15:0] ymin, input logic [15:0] ymax,
                                       input logic [23:0] cnt, input logic valid);
    return {xmin, xmax, ymin, ymax, cnt, valid};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_result(input string who, input logic [88:0] act, input logic [88:0] exp);
    chk({who, " x_min"}, 32'(act[88:73]), 32'(exp[88:73]));
    chk({who, " x_max"}, 32'(act[72:57]), 32'(exp[72:57]));
    chk({who, " y_min"}, 32'(act[56:41]), 32'(exp[56:41]));
    chk({who, " y_max"}, 32'(act[40:25]), 32'(exp[40:25]));
    chk({who, " pix_cnt"}, 32'(act[24:1]), 32'(exp[24:1]));
    chk({who, " box_valid"}, 32'(act[0]), 32'(exp[0]));
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge video_clk) begin
    if (rst_n && result_vld) begin
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL dut4 result_vld: got unexpected pulse, expected none");
      end else begin
        cmp_result("dut4", {box_x_min, box_x_max, box_y_min, box_y_max, pix_cnt, box_valid},
                   exp_q.pop_front());
      end
    end
  end

  always @(negedge video_clk) begin
    if (rst_n && b3_vld) begin
      if (exp3_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL dut3 result_vld: got unexpected pulse, expected none");
      end else begin
        cmp_result("dut3", {b3_x_min, b3_x_max, b3_y_min, b3_y_max, b3_cnt, b3_valid},
                   exp3_q.pop_front());
      end
    end
  end

`ifdef BBOX_OVERLAY_EN
  // Overlay check for the frame following the (5,7,2,3) box. That box is
  // 3x2, so every pixel inside it lies on its border.
  bit ovl_chk = 1'b0;
  bit p_chk;
  int drv_x, drv_y, p_x, p_y;
  logic p_de, p_data;
  always @(posedge video_clk) begin
    p_chk  <= ovl_chk;
    p_x    <= drv_x;
    p_y    <= drv_y;
    p_de   <= bin_de;
    p_data <= bin_data;
  end
  always @(negedge video_clk) begin
    if (p_chk) begin
      chk("ovl_de", 32'(ovl_de), 32'(p_de));
      if (p_de) begin
        if (p_x >= 5 && p_x <= 7 && p_y >= 2 && p_y <= 3)
          chk("ovl_data border", 32'(ovl_data), 32'h00FF0000);
        else
          chk("ovl_data pass", 32'(ovl_data), 32'({24{p_data}}));
      end
    end
  end
`endif

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge video_clk);
    #1;
  endtask

  task automatic clear_img();
    for (int l = 0; l < H; l++) begin
      img[l] = '0;
      len[l] = W;
    end
  endtask

  // fall_pixel: drop bin_vs on the last pixel of the last line.
  // rst_line  : pulse rst_n at the start of that line (-1 = none).
  task automatic send_frame(input bit fall_pixel, input int rst_line, input bit expect_result);
    logic [31:0] row;
    bin_vs = 1'b1; bin_de = 1'b0; bin_data = 1'b0;
    tick(); tick();
    for (int l = 0; l < H; l++) begin
      if (l == rst_line) begin
        rst_n = 1'b0;
        tick();
        chk("midframe reset pix_cnt", 32'(pix_cnt), 32'd0);
        chk("midframe reset dut3 x_max", 32'(b3_x_max), 32'd0);
        chk("midframe reset dut3 valid", 32'(b3_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
      end
      row = img[l];
      for (int p = 0; p < len[l]; p++) begin
        bin_de = 1'b1; bin_data = row[p];
`ifdef BBOX_OVERLAY_EN
        drv_x = p; drv_y = l;
`endif
        if (fall_pixel && l == H-1 && p == len[l]-1) begin
          bin_vs = 1'b0;
          tick();
          @(negedge video_clk);
          chk("latency result_vld", 32'(result_vld), 32'(expect_result));
        end else begin
          tick();
        end
      end
      bin_de = 1'b0; bin_data = 1'b0;
      tick(); tick();
    end
    if (!fall_pixel) begin
      bin_vs = 1'b0;
      tick();
      @(negedge video_clk);
      chk("latency result_vld", 32'(result_vld), 32'(expect_result));
    end
    tick();
    @(negedge video_clk);
    chk("result_vld width", 32'(result_vld), 32'd0);
    repeat (3) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; bin_vs = 1'b0; bin_de = 1'b0; bin_data = 1'b0;
    repeat (3) tick();
    @(negedge video_clk);
    chk("reset x_min", 32'(box_x_min), 32'd0);
    chk("reset x_max", 32'(box_x_max), 32'd0);
    chk("reset y_min", 32'(box_y_min), 32'd0);
    chk("reset y_max", 32'(box_y_max), 32'd0);
    chk("reset pix_cnt", 32'(pix_cnt), 32'd0);
    chk("reset box_valid", 32'(box_valid), 32'd0);
    chk("reset result_vld", 32'(result_vld), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // 1: solid 3x2 block at x=5..7, y=2..3
    clear_img();
    img[2] = 32'h0000_00E0; img[3] = 32'h0000_00E0;
    exp_q.push_back (pack(16'd5, 16'd7, 16'd2, 16'd3, 24'd6, 1'b1));
    exp3_q.push_back(pack(16'd5, 16'd7, 16'd2, 16'd3, 24'd6, 1'b1));
    send_frame(1'b0, -1, 1'b1);

    // 2: isolated pixels (0,0), (15,7), (8,4); overlay of box from frame 1
    clear_img();
    img[0] = 32'h0000_0001; img[7] = 32'h0000_8000; img[4] = 32'h0000_0100;
    exp_q.push_back (pack(16'd0, 16'd0,  16'd0, 16'd0, 24'd3, 1'b0));
    exp3_q.push_back(pack(16'd0, 16'd15, 16'd0, 16'd7, 24'd3, 1'b1));
`ifdef BBOX_OVERLAY_EN
    ovl_chk = 1'b1;
`endif
    send_frame(1'b0, -1, 1'b1);
`ifdef BBOX_OVERLAY_EN
    ovl_chk = 1'b0;
`endif

    // 3: reset pulsed mid-frame with foreground present: no result
    clear_img();
    for (int l = 0; l < H; l++) img[l] = 32'h0000_FFFF;
    send_frame(1'b0, 3, 1'b0);

    // 4: full frame after the reset, 2x2 block at x=10..11, y=5..6
    clear_img();
    img[5] = 32'h0000_0C00; img[6] = 32'h0000_0C00;
    exp_q.push_back (pack(16'd10, 16'd11, 16'd5, 16'd6, 24'd4, 1'b1));
    exp3_q.push_back(pack(16'd10, 16'd11, 16'd5, 16'd6, 24'd4, 1'b1));
    send_frame(1'b0, -1, 1'b1);

    // 5: all-zero frame
    clear_img();
    exp_q.push_back (pack(16'd0, 16'd0, 16'd0, 16'd0, 24'd0, 1'b0));
    exp3_q.push_back(pack(16'd0, 16'd0, 16'd0, 16'd0, 24'd0, 1'b0));
    send_frame(1'b0, -1, 1'b1);

    // 6: (12..14,6) plus (15,7) presented on the bin_vs fall cycle
    clear_img();
    img[6] = 32'h0000_7000; img[7] = 32'h0000_8000;
    exp_q.push_back (pack(16'd12, 16'd15, 16'd6, 16'd7, 24'd4, 1'b1));
    exp3_q.push_back(pack(16'd12, 16'd15, 16'd6, 16'd7, 24'd4, 1'b1));
    send_frame(1'b1, -1, 1'b1);

    // 7: over-long line 1 (20 pixels), foreground at 17..19 reports x=15
    clear_img();
    img[0] = 32'h0000_0004; len[1] = 20; img[1] = 32'h000E_0000;
    exp_q.push_back (pack(16'd2, 16'd15, 16'd0, 16'd1, 24'd4, 1'b1));
    exp3_q.push_back(pack(16'd2, 16'd15, 16'd0, 16'd1, 24'd4, 1'b1));
    send_frame(1'b0, -1, 1'b1);

    for (int i = 0; i < 20 && (exp_q.size() != 0 || exp3_q.size() != 0); i++) tick();
    chk("dut4 pending results", 32'(exp_q.size()), 32'd0);
    chk("dut3 pending results", 32'(exp3_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
